// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency-meter measurement stage.
package freq_meter_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned SYS_CLK_HZ = 100_000_000;

    localparam type bcd_digit_t = logic [BCD_W-1:0];

    typedef enum logic {
        START,
        GATE
    } state_e;

endpackage

// File: rtl/freq_counter_if.sv
// Result bus from the measurement stage to the display driver.
interface freq_counter_if #(
    parameter int unsigned DIGITS = 6
);
    import freq_meter_pkg::*;

    logic [BCD_W*DIGITS-1:0] freq_bcd;
    logic                    freq_valid;
    logic                    overflow;
    logic                    gate_active;

    modport master (
        output freq_bcd,
        output freq_valid,
        output overflow,
        output gate_active
    );

    modport slave (
        input freq_bcd,
        input freq_valid,
        input overflow,
        input gate_active
    );

endinterface

// File: rtl/bcd_digit.sv
// One decade of the ripple-carry BCD edge counter.
module bcd_digit
    import freq_meter_pkg::*;
(
    input  logic       sysclk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output bcd_digit_t digit,
    output logic       carry
);

    bcd_digit_t digit_q;

    // digit is the value including this cycle's increment, so a gate boundary can latch it
    // while the register itself clears.
    always_comb begin
        digit = digit_q;
        carry = 1'b0;
        if (inc) begin
            if (digit_q == bcd_digit_t'(9)) begin
                digit = '0;
                carry = 1'b1;
            end else begin
                digit = digit_q + bcd_digit_t'(1);
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            digit_q <= '0;
        end else if (clr) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit;
        end
    end

endmodule

// File: rtl/freq_counter.sv
// Frequency-meter measurement stage: counts sigin rising edges over back-to-back gate windows
// and publishes packed BCD in Hz. Macro FREQ_COUNTER_FAST_GATE_EN adds a 1/10-length gate.
module freq_counter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = SYS_CLK_HZ,
    parameter int unsigned DIGITS      = 6
) (
    input  logic sysclk,
    input  logic reset,
    input  logic sigin,
`ifdef FREQ_COUNTER_FAST_GATE_EN
    input  logic fast_gate,
`endif
    freq_counter_if.master res
);

    localparam int unsigned TIMER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned CNT_W   = BCD_W * DIGITS;
    localparam logic [TIMER_W-1:0] LAST_FULL = TIMER_W'(GATE_CYCLES - 1);

    logic sync1_q, sync_q, delay_q, edge_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            delay_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sigin;
            sync_q  <= sync1_q;
            delay_q <= sync_q;
            edge_q  <= sync_q & ~delay_q;
        end
    end

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TIMER_W-1:0] last;
    logic               clr;
    logic               boundary;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TIMER_W'(1);
        clr      = 1'b0;
        boundary = 1'b0;
        unique case (state_q)
            START: begin
                state_d = GATE;
                timer_d = '0;
                clr     = 1'b1;
            end
            GATE: begin
                // Stay in GATE across the boundary so consecutive windows abut.
                if (timer_q == last) begin
                    boundary = 1'b1;
                    timer_d  = '0;
                    clr      = 1'b1;
                end
            end
            default: state_d = START;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= START;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    logic [DIGITS-1:0] inc;
    logic [DIGITS-1:0] carry;
    logic [CNT_W-1:0]  count;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign inc[i] = edge_q;
        end else begin : g_upper
            assign inc[i] = carry[i-1];
        end
        bcd_digit u_digit (
            .sysclk (sysclk),
            .reset  (reset),
            .inc    (inc[i]),
            .clr    (clr),
            .digit  (count[i*BCD_W +: BCD_W]),
            .carry  (carry[i])
        );
    end

    logic             wrap;
    logic [CNT_W-1:0] result;

`ifdef FREQ_COUNTER_FAST_GATE_EN
    localparam logic [TIMER_W-1:0] LAST_FAST = TIMER_W'(GATE_CYCLES / 10 - 1);

    logic fast_q;

    // Sampled only at gate start so a mid-gate change applies to the following window.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            fast_q <= 1'b0;
        end else if (clr) begin
            fast_q <= fast_gate;
        end
    end

    assign last   = fast_q ? LAST_FAST : LAST_FULL;
    assign wrap   = fast_q ? carry[DIGITS-2] : carry[DIGITS-1];
    assign result = fast_q ? {count[CNT_W-BCD_W-1:0], BCD_W'(0)} : count;
`else
    assign last   = LAST_FULL;
    assign wrap   = carry[DIGITS-1];
    assign result = count;
`endif

    logic             ovf_flag_q;
    logic [CNT_W-1:0] bcd_q;
    logic             valid_q;
    logic             ovf_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            ovf_flag_q <= 1'b0;
        end else if (clr) begin
            ovf_flag_q <= 1'b0;
        end else if (wrap) begin
            ovf_flag_q <= 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            bcd_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= boundary;
            if (boundary) begin
                bcd_q <= result;
                ovf_q <= ovf_flag_q | wrap;
            end
        end
    end

    assign res.freq_bcd    = bcd_q;
    assign res.freq_valid  = valid_q;
    assign res.overflow    = ovf_q;
    assign res.gate_active = (state_q == GATE);

endmodule

// File: tb/tb_freq_counter.sv
// Scoreboard bench: two freq_counter instances (6 and 2 digits) share one stimulus stream.
module tb_freq_counter;

    localparam int unsigned G = 1000;

    typedef struct {
        logic        check;
        logic [23:0] bcd;
        logic [23:0] alt;
        logic        ovf;
        int unsigned gap;
    } exp_t;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    logic sigin  = 1'b0;
`ifdef FREQ_COUNTER_FAST_GATE_EN
    logic fast_gate = 1'b0;
`endif

    int unsigned per     = 40;
    logic        hold    = 1'b0;
    int unsigned cyc     = 0;
    int unsigned ref_cyc = 0;
    int          tests   = 0;
    int          fails   = 0;
    exp_t        q6[$];
    exp_t        q2[$];

    freq_counter_if #(.DIGITS(6)) res6 ();
    freq_counter_if #(.DIGITS(2)) res2 ();

    freq_counter #(.GATE_CYCLES(G), .DIGITS(6)) dut6 (
        .sysclk    (sysclk),
        .reset     (reset),
        .sigin     (sigin),
`ifdef FREQ_COUNTER_FAST_GATE_EN
        .fast_gate (fast_gate),
`endif
        .res       (res6)
    );

    freq_counter #(.GATE_CYCLES(G), .DIGITS(2)) dut2 (
        .sysclk    (sysclk),
        .reset     (reset),
        .sigin     (sigin),
`ifdef FREQ_COUNTER_FAST_GATE_EN
        .fast_gate (fast_gate),
`endif
        .res       (res2)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp,
                       input logic [31:0] alt);
        tests++;
        assert (got === exp || got === alt) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One unchecked transition gate, then n gates of a settled pattern.
    task automatic seg(input int unsigned skip_gap, input int unsigned n,
                       input logic [23:0] b6, input logic [23:0] a6,
                       input logic [23:0] b2, input logic [23:0] a2, input logic o2,
                       input int unsigned gap);
        q6.push_back('{1'b0, 24'h0, 24'h0, 1'b0, skip_gap});
        q2.push_back('{1'b0, 24'h0, 24'h0, 1'b0, 0});
        repeat (n) begin
            q6.push_back('{1'b1, b6, a6, 1'b0, gap});
            q2.push_back('{1'b1, b2, a2, o2, 0});
        end
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while (q6.size() != 0 && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        chk("drain_pending", q6.size(), 0, 0);
        q6.delete();
        q2.delete();
    endtask

    // sigin generator: period per (50% duty), or constant hold when per == 0.
    initial begin
        int unsigned ph = 0;
        forever begin
            @(posedge sysclk);
            #2;
            if (per == 0) begin
                sigin = hold;
            end else begin
                sigin = (ph >= per / 2);
                ph = (ph + 1 >= per) ? 0 : ph + 1;
            end
        end
    end

    // Monitor: pop and compare on every freq_valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge sysclk);
            if (res6.freq_valid) begin
                chk("valid6_expected", 32'(q6.size() != 0), 1, 1);
                if (q6.size() != 0) begin
                    e = q6.pop_front();
                    if (e.gap != 0) chk("valid6_gap", cyc - ref_cyc, e.gap, e.gap);
                    if (e.check) begin
                        chk("bcd6", 32'(res6.freq_bcd), 32'(e.bcd), 32'(e.alt));
                        chk("ovf6", 32'(res6.overflow), 32'(e.ovf), 32'(e.ovf));
                    end
                end
                ref_cyc = cyc;
            end
            if (res2.freq_valid) begin
                chk("valid2_expected", 32'(q2.size() != 0), 1, 1);
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    if (e.check) begin
                        chk("bcd2", 32'(res2.freq_bcd), 32'(e.bcd[7:0]), 32'(e.alt[7:0]));
                        chk("ovf2", 32'(res2.overflow), 32'(e.ovf), 32'(e.ovf));
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned low;

        repeat (3) @(negedge sysclk);
        chk("rst_bcd6", 32'(res6.freq_bcd), 0, 0);
        chk("rst_valid6", 32'(res6.freq_valid), 0, 0);
        chk("rst_ovf6", 32'(res6.overflow), 0, 0);
        chk("rst_gate6", 32'(res6.gate_active), 0, 0);

        // Period 40: 25 edges per 1000-cycle gate; first gate unchecked, arrives at 1+G+1.
        seg(G + 2, 3, 24'h25, 24'h25, 24'h25, 24'h25, 1'b0, G);
        reset = 1'b0;
        ref_cyc = cyc - 1;  // the START cycle counts as cycle 1
        repeat (5) @(negedge sysclk);
        chk("gate_active6", 32'(res6.gate_active), 1, 1);
        chk("gate_active2", 32'(res2.gate_active), 1, 1);
        drain(6 * G);

        // Period 8: 125 edges; the 2-digit instance wraps to 25 and flags overflow.
        per = 8;
        seg(G, 2, 24'h125, 24'h125, 24'h25, 24'h25, 1'b1, G);
        drain(5 * G);

        // Back to period 40: overflow must clear.
        per = 40;
        seg(G, 2, 24'h25, 24'h25, 24'h25, 24'h25, 1'b0, G);
        drain(5 * G);

        // Constant low, then constant high.
        per = 0;
        hold = 1'b0;
        seg(G, 2, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, G);
        drain(5 * G);
        hold = 1'b1;
        seg(G, 2, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, G);
        drain(5 * G);

        // Reset midway through a gate with sigin toggling.
        per = 40;
        seg(G, 1, 24'h25, 24'h25, 24'h25, 24'h25, 1'b0, G);
        drain(4 * G);
        repeat (498) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        chk("midrst_bcd6", 32'(res6.freq_bcd), 0, 0);
        chk("midrst_valid6", 32'(res6.freq_valid), 0, 0);
        chk("midrst_ovf6", 32'(res6.overflow), 0, 0);
        chk("midrst_gate6", 32'(res6.gate_active), 0, 0);
        chk("midrst_bcd2", 32'(res2.freq_bcd), 0, 0);
        // Release while sigin has been low a while so no phantom edge enters the pipeline.
        low = 0;
        for (int i = 0; i < 200 && low < 3; i++) begin
            @(negedge sysclk);
            low = sigin ? 0 : low + 1;
        end
        q6.push_back('{1'b1, 24'h25, 24'h25, 1'b0, G + 2});
        q2.push_back('{1'b1, 24'h25, 24'h25, 1'b0, 0});
        reset = 1'b0;
        ref_cyc = cyc - 1;
        drain(3 * G);

`ifdef FREQ_COUNTER_FAST_GATE_EN
        per = 8;
        seg(G, 1, 24'h125, 24'h125, 24'h25, 24'h25, 1'b1, G);
        drain(4 * G);
        // Set mid-gate: current gate keeps full length, then 100-cycle windows.
        fast_gate = 1'b1;
        seg(G, 2, 24'h120, 24'h130, 24'h20, 24'h30, 1'b1, G / 10);
        drain(4 * G);
        fast_gate = 1'b0;
        seg(G / 10, 1, 24'h125, 24'h125, 24'h25, 24'h25, 1'b1, G);
        drain(4 * G);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
